// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the accumulator-machine control unit.
// Holds the opcode field values, the accumulator source-select codes, the
// controller state enumeration and the opcode-to-execute-state decode.
package cu_pkg;

   localparam int PC_W = 5;

   // Instruction opcodes, IR[7:5]
   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_STORE = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_INPUT = 3'b100;
   localparam logic [2:0] OP_JZ    = 3'b101;
   localparam logic [2:0] OP_JPOS  = 3'b110;
   localparam logic [2:0] OP_HALT  = 3'b111;

   // Accumulator source select
   localparam logic [1:0] ASEL_ADDER = 2'b00;
   localparam logic [1:0] ASEL_INPUT = 2'b01;
   localparam logic [1:0] ASEL_MEM   = 2'b10;
   localparam logic [1:0] ASEL_GND   = 2'b11;

   typedef enum logic [3:0] {
      S_INIT,
      S_FETCH,
      S_DECODE,
      S_LOAD,
      S_STORE,
      S_ADD,
      S_SUB,
      S_INPUT,
      S_JZ,
      S_JPOS,
      S_HALT
   } state_t;

   // Map an opcode to the execute state that carries it out
   function automatic state_t decode_op(input logic [2:0] op);
      state_t s;
      case (op)
         OP_LOAD:  s = S_LOAD;
         OP_STORE: s = S_STORE;
         OP_ADD:   s = S_ADD;
         OP_SUB:   s = S_SUB;
         OP_INPUT: s = S_INPUT;
         OP_JZ:    s = S_JZ;
         OP_JPOS:  s = S_JPOS;
         default:  s = S_HALT;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/program_counter.sv
// program_counter: 5-bit program counter with synchronous reset,
// parallel load and increment. Load wins over increment; the increment
// wraps from 31 back to 0.
module program_counter
   import cu_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            inc,
   input  logic            load,
   input  logic [PC_W-1:0] d,
   output logic [PC_W-1:0] q
);

   // Counter register: reset, then load, then increment
   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (load)
         q <= d;
      else if (inc)
         q <= q + 1'b1;
   end

endmodule

// File: rtl/control_unit.sv
// control_unit: FETCH/DECODE/EXECUTE sequencer for a small accumulator
// machine with a 32-word RAM. Each instruction takes FETCH, DECODE and one
// execute cycle; INPUT waits in its execute state until enter is seen.
// Control outputs are decoded from the state (loadA in INPUT also follows
// enter) and are forced to the INIT pattern while reset is high, so a
// reset landing on a STORE cycle never produces a write.
// Optional build macro: HALT_RESUME_EN -- when defined, enter=1 in HALT
// resumes fetching at the current PC; otherwise HALT is left only by reset.
module control_unit
   import cu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       enter,
   input  logic       Aeq0,
   input  logic       Apos,
   input  logic [7:0] mem_data,
   output logic [4:0] mem_addr,
   output logic       mem_wr,
   output logic [7:0] ir_out,
   output logic [1:0] Asel,
   output logic       loadA,
   output logic       clearA,
   output logic       sub,
   output logic       halt
);

   state_t          state;
   logic [7:0]      ir;
   logic [PC_W-1:0] pc;
   logic            pc_inc;
   logic            pc_load;
   logic [PC_W-1:0] pc_d;

   program_counter u_pc (
      .clk   (clk),
      .reset (reset),
      .inc   (pc_inc),
      .load  (pc_load),
      .d     (pc_d),
      .q     (pc)
   );

   // PC control: clear in INIT, step in FETCH, conditional jump in JZ/JPOS
   always_comb begin
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      pc_d    = ir[4:0];
      case (state)
         S_INIT: begin
            pc_load = 1'b1;
            pc_d    = '0;
         end
         S_FETCH: pc_inc  = 1'b1;
         S_JZ:    pc_load = Aeq0;
         S_JPOS:  pc_load = Apos;
         default: ;
      endcase
   end

   // Sequencer state and instruction register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_INIT;
         ir    <= '0;
      end else begin
         case (state)
            S_INIT:   state <= S_FETCH;
            S_FETCH: begin
               ir    <= mem_data;
               state <= S_DECODE;
            end
            S_DECODE: state <= decode_op(ir[7:5]);
            S_INPUT: begin
               if (enter)
                  state <= S_FETCH;
            end
            S_HALT: begin
`ifdef HALT_RESUME_EN
               if (enter)
                  state <= S_FETCH;
`else
               state <= S_HALT;
`endif
            end
            S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS:
               state <= S_FETCH;
            default:  state <= S_INIT;
         endcase
      end
   end

   // Control outputs decoded from the state, overridden while reset is high
   always_comb begin
      mem_addr = '0;
      mem_wr   = 1'b0;
      Asel     = ASEL_ADDER;
      loadA    = 1'b0;
      clearA   = 1'b0;
      sub      = 1'b0;
      halt     = 1'b0;
      if (reset) begin
         clearA = 1'b1;
      end else begin
         case (state)
            S_INIT:   clearA = 1'b1;
            S_FETCH:  mem_addr = pc;
            S_DECODE: mem_addr = ir[4:0];
            S_LOAD: begin
               mem_addr = ir[4:0];
               Asel     = ASEL_MEM;
               loadA    = 1'b1;
            end
            S_STORE: begin
               mem_addr = ir[4:0];
               mem_wr   = 1'b1;
            end
            S_ADD: begin
               mem_addr = ir[4:0];
               loadA    = 1'b1;
            end
            S_SUB: begin
               mem_addr = ir[4:0];
               sub      = 1'b1;
               loadA    = 1'b1;
            end
            S_INPUT: begin
               mem_addr = ir[4:0];
               Asel     = ASEL_INPUT;
               loadA    = enter;
            end
            S_JZ, S_JPOS: mem_addr = ir[4:0];
            S_HALT: begin
               mem_addr = ir[4:0];
               halt     = 1'b1;
            end
            default: clearA = 1'b1;
         endcase
      end
   end

   // IR is visible except while reset or INIT is presenting the cleared state
   always_comb begin
      ir_out = ir;
      if (reset || state == S_INIT)
         ir_out = '0;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high; the only clock and reset are clk and reset.
REQ-003 SHALL have port enter, input, 1, user-input-ready strobe.
REQ-004 SHALL have ports Aeq0 and Apos, input, 1 each, accumulator status flags from the datapath.
REQ-005 SHALL have port mem_data, input, 8, RAM read data (combinational read).
REQ-006 SHALL have port mem_addr, output, 5, RAM address.
REQ-007 SHALL have port mem_wr, output, 1, RAM write strobe.
REQ-008 SHALL have port ir_out, output, 8, instruction register contents.
REQ-009 SHALL have port Asel, output, 2, accumulator source select: 00 adder, 01 Input, 10 IROut/memory, 11 GND.
REQ-010 SHALL have ports loadA, clearA and sub, output, 1 each, accumulator load, accumulator clear and subtract select.
REQ-011 SHALL have port halt, output, 1, processor halted.

Function
REQ-012 SHALL implement FSM states INIT, FETCH, DECODE, LOAD, STORE, ADD, SUB, INPUT, JZ, JPOS and HALT.
REQ-013 INIT SHALL last one cycle, assert clearA=1, set PC=0, then go to FETCH.
REQ-014 FETCH SHALL drive mem_addr=PC, latch IR<=mem_data, set PC<=PC+1 (5-bit, 31 wraps to 0), then go to DECODE.
REQ-015 DECODE SHALL drive mem_addr=IR[4:0] and branch on IR[7:5]: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 INPUT, 101 JZ, 110 JPOS, 111 HALT.
REQ-016 In every execute state mem_addr SHALL equal IR[4:0].
REQ-017 LOAD SHALL assert Asel=10 and loadA=1 for one cycle, then go to FETCH.
REQ-018 STORE SHALL assert mem_wr=1 for exactly one cycle, then go to FETCH.
REQ-019 ADD SHALL assert Asel=00, sub=0 and loadA=1 for one cycle, then go to FETCH.
REQ-020 SUB SHALL assert Asel=00, sub=1 and loadA=1 for one cycle, then go to FETCH.
REQ-021 INPUT SHALL hold in place while enter=0; on the cycle with enter=1 it SHALL assert Asel=01 and loadA=1, then go to FETCH.
REQ-022 JZ SHALL sample Aeq0 in its single cycle and, if it is 1, set PC<=IR[4:0]; it then goes to FETCH. JPOS SHALL do the same using Apos.
REQ-023 HALT SHALL assert halt=1 and keep loadA, mem_wr and clearA at 0.
REQ-024 Every control output not named for the current state SHALL be 0.
REQ-025 All outputs SHALL be Moore (state-only) outputs, except: loadA in INPUT, which depends on enter; and mem_addr, which depends on PC/IR.
REQ-026 Each instruction SHALL take 3 cycles (FETCH, DECODE, execute), except INPUT, which takes 3 cycles plus its wait cycles.

Reset
REQ-027 reset=1 SHALL force state=INIT, PC=0 and IR=0 on the next edge, and SHALL override enter, pending jumps and writes.
REQ-028 While reset=1 or in INIT, outputs SHALL be mem_wr=0, loadA=0, sub=0, Asel=00, halt=0, mem_addr=0, ir_out=0 and clearA=1.
REQ-029 Reset asserted mid-instruction, including during STORE, SHALL suppress mem_wr in that cycle.

Configuration
REQ-030 Macro HALT_RESUME_EN defined: in HALT, enter=1 SHALL move the FSM to FETCH and resume at the current PC.
REQ-031 Macro HALT_RESUME_EN undefined: HALT SHALL be terminal until reset, and enter SHALL be ignored.

Structure
REQ-032 Package cu_pkg SHALL hold the opcode constants, the Asel codes and the state enumeration.
REQ-033 The PC SHALL be a sub-module program_counter with clk, reset, inc, load, d[4:0] and q[4:0]; load has priority over inc.

Verification
REQ-034 Reset, then fetch 8'h05 (LOAD 5) with mem[5]=8'h2A -> clearA in INIT; Asel=10, loadA=1 in cycle 4; mem_addr=5 during execute.
REQ-035 IR=8'h65 (SUB 5) -> sub=1, Asel=00, loadA=1 for one cycle only.
REQ-036 IR=8'h83 (INPUT), enter held low for 4 cycles, then high -> FSM remains in INPUT with loadA=0 during the wait; Asel=01, loadA=1 in the enter cycle; next state FETCH.
REQ-037 IR=8'hA7 (JZ 7) with Aeq0=1 -> next fetch at mem_addr=7; same with Aeq0=0 -> next fetch at PC+1. IR=8'hC7 (JPOS 7) with Apos=0 -> no jump.
REQ-038 PC=31, fetch -> PC wraps to 0. Reset asserted during STORE -> mem_wr=0 and state INIT.
REQ-039 IR=8'hE0 (HALT) -> halt=1 and stays. enter=1 -> resumes to FETCH only if HALT_RESUME_EN is defined; otherwise halt stays 1.
